// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter controller that launches, steps, branches, stalls and halts ROM fetch
module fetch_sequencer #(
    parameter int D        = 12,
    parameter int P1_START = 0,
    parameter int P2_START = 128,
    parameter int P3_START = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   prog_sel,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch_en,
    input  logic         branch_rel,
    input  logic [D-1:0] branch_tgt,
    output logic [D-1:0] prog_ctr,
    output logic         fetch_valid,
    output logic         busy,
    output logic         done,
    output logic         sel_err,
    output logic [15:0]  instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [D-1:0] start_pc, next_pc;
    logic [15:0] count_inc;
    always_comb begin
        start_pc  = (prog_sel == 2'd1) ? D'(P1_START) : (prog_sel == 2'd2) ? D'(P2_START) : D'(P3_START);
        next_pc   = branch_en ? (branch_rel ? prog_ctr + branch_tgt : branch_tgt) : prog_ctr + D'(1);
        count_inc = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            prog_ctr    <= '0;
            instr_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fetch_valid <= 1'b0;
            sel_err     <= 1'b0;
        end else if (state == RUN) begin
            // stall freezes everything; halt outranks any branch
            if (!stall) begin
                instr_count <= count_inc;
                if (halt) begin
                    state       <= DONE;
                    busy        <= 1'b0;
                    fetch_valid <= 1'b0;
                    done        <= 1'b1;
                end else begin
                    prog_ctr <= next_pc;
                end
            end
        end else if (start) begin
            if (prog_sel == 2'd0) begin
                sel_err <= 1'b1;
            end else begin
                state       <= RUN;
                prog_ctr    <= start_pc;
                instr_count <= '0;
                busy        <= 1'b1;
                fetch_valid <= 1'b1;
                done        <= 1'b0;
                sel_err     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table plus hand sequences, expected outputs queued and popped after each edge
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stall, halt, branch_en, branch_rel;
    logic [1:0]  prog_sel;
    logic [11:0] branch_tgt, prog_ctr;
    logic        fetch_valid, busy, done, sel_err;
    logic [15:0] instr_count;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] pc;
        logic        v, b, d, e;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic        start;
        logic [1:0]  sel;
        logic        stall, halt, br, rel;
        logic [11:0] tgt;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[22];

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .prog_sel(prog_sel),
        .stall(stall), .halt(halt), .branch_en(branch_en), .branch_rel(branch_rel),
        .branch_tgt(branch_tgt), .prog_ctr(prog_ctr), .fetch_valid(fetch_valid),
        .busy(busy), .done(done), .sel_err(sel_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic sl, input logic h,
                                input logic br, input logic rel, input logic [11:0] tgt,
                                input logic [11:0] pc, input logic v, input logic b, input logic d,
                                input logic e, input logic [15:0] cnt);
        vec_t r;
        r.start = st; r.sel = sel; r.stall = sl; r.halt = h; r.br = br; r.rel = rel; r.tgt = tgt;
        r.exp = '{pc: pc, v: v, b: b, d: d, e: e, cnt: cnt};
        return r;
    endfunction

    task automatic compare(input string name);
        exp_t e, a;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        a = '{pc: prog_ctr, v: fetch_valid, b: busy, d: done, e: sel_err, cnt: instr_count};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got pc=%0d valid=%0b busy=%0b done=%0b sel_err=%0b count=%0d, expected pc=%0d valid=%0b busy=%0b done=%0b sel_err=%0b count=%0d",
                     name, a.pc, a.v, a.b, a.d, a.e, a.cnt, e.pc, e.v, e.b, e.d, e.e, e.cnt);
        end
    endtask

    task automatic apply(input vec_t x, input string name);
        @(negedge clk);
        start = x.start; prog_sel = x.sel; stall = x.stall; halt = x.halt;
        branch_en = x.br; branch_rel = x.rel; branch_tgt = x.tgt;
        sb.push_back(x.exp);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic plain_cycles(input int n);
        @(negedge clk);
        start = 0; prog_sel = 0; stall = 0; halt = 0; branch_en = 0; branch_rel = 0; branch_tgt = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0,0,0,0,0,0,12'd0,    12'd0,   0,0,0,0,16'd0);
        vecs[1]  = mk(1,2,0,0,0,0,12'd0,    12'd128, 1,1,0,0,16'd0);
        vecs[2]  = mk(0,0,0,0,0,0,12'd0,    12'd129, 1,1,0,0,16'd1);
        vecs[3]  = mk(0,0,0,0,0,0,12'd0,    12'd130, 1,1,0,0,16'd2);
        vecs[4]  = mk(0,0,0,0,0,0,12'd0,    12'd131, 1,1,0,0,16'd3);
        vecs[5]  = mk(0,0,0,0,0,0,12'd0,    12'd132, 1,1,0,0,16'd4);
        vecs[6]  = mk(1,1,0,0,0,0,12'd0,    12'd133, 1,1,0,0,16'd5);
        vecs[7]  = mk(0,0,0,0,1,0,12'd140,  12'd140, 1,1,0,0,16'd6);
        vecs[8]  = mk(0,0,0,0,1,1,12'hFFB,  12'd135, 1,1,0,0,16'd7);
        vecs[9]  = mk(0,0,0,0,1,0,12'd300,  12'd300, 1,1,0,0,16'd8);
        vecs[10] = mk(0,0,1,1,1,0,12'd50,   12'd300, 1,1,0,0,16'd8);
        vecs[11] = mk(0,0,1,1,1,0,12'd50,   12'd300, 1,1,0,0,16'd8);
        vecs[12] = mk(0,0,1,1,1,0,12'd50,   12'd300, 1,1,0,0,16'd8);
        vecs[13] = mk(0,0,0,1,0,0,12'd0,    12'd300, 0,0,1,0,16'd9);
        vecs[14] = mk(1,0,0,0,0,0,12'd0,    12'd300, 0,0,1,1,16'd9);
        vecs[15] = mk(1,3,0,0,0,0,12'd0,    12'd256, 1,1,0,0,16'd0);
        vecs[16] = mk(0,0,0,0,1,1,12'hEFF,  12'd4095,1,1,0,0,16'd1);
        vecs[17] = mk(0,0,0,0,0,0,12'd0,    12'd0,   1,1,0,0,16'd2);
        vecs[18] = mk(0,0,0,1,1,0,12'd50,   12'd0,   0,0,1,0,16'd3);
        vecs[19] = mk(1,0,0,0,0,0,12'd0,    12'd0,   0,0,1,1,16'd3);
        vecs[20] = mk(1,1,0,0,0,0,12'd0,    12'd0,   1,1,0,0,16'd0);
        vecs[21] = mk(0,0,0,0,0,0,12'd0,    12'd1,   1,1,0,0,16'd1);

        reset_n = 0; start = 0; prog_sel = 0; stall = 0; halt = 0;
        branch_en = 0; branch_rel = 0; branch_tgt = 0;
        #12;
        sb.push_back('0);
        compare("reset_state");
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 22; i++) apply(vecs[i], $sformatf("vec%0d", i));

        plain_cycles(199);
        sb.push_back('{pc: 12'd200, v: 1, b: 1, d: 0, e: 0, cnt: 16'd200});
        compare("run_to_200");
        #2;
        reset_n = 0;
        #1;
        sb.push_back('0);
        compare("async_reset_mid_run");
        @(negedge clk);
        reset_n = 1;
        apply(mk(0,0,0,0,0,0,12'd0, 12'd0,0,0,0,0,16'd0), "idle_after_reset");

        apply(mk(1,1,0,0,0,0,12'd0, 12'd0,1,1,0,0,16'd0), "start_prog1");
        plain_cycles(65540);
        sb.push_back('{pc: 12'd4, v: 1, b: 1, d: 0, e: 0, cnt: 16'hFFFF});
        compare("count_saturates");
        apply(mk(0,0,0,1,0,0,12'd0, 12'd4,0,0,1,0,16'hFFFF), "halt_saturated");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
